fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: redirect_valid  input  1  one-cycle pulse requesting a PC redirect (branch or jump resolved).
REQ-005 Port: redirect_target  input  32  new fetch address, valid when redirect_valid=1.
REQ-006 Port: imem_req  output  1  instruction memory request.
REQ-007 Port: imem_addr  output  32  request address, word-aligned.
REQ-008 Port: imem_gnt  input  1  request accepted in the same cycle imem_req=1.
REQ-009 Port: imem_rvalid  input  1  response valid; earliest one cycle after the grant.
REQ-010 Port: imem_rdata  input  32  response instruction word.
REQ-011 Port: if_valid  output  1  an instruction is held for decode.
REQ-012 Port: if_ready  input  1  decode accepts the instruction when if_valid=1 and if_ready=1.
REQ-013 Port: if_instr  output  32  fetched instruction.
REQ-014 Port: if_pc  output  32  address of if_instr.

Function
REQ-015 State: pc register (32 bits), FSM {REQ, WAIT}, discard flag, one-entry output buffer (if_valid, if_instr, if_pc); at most one memory request outstanding.
REQ-016 imem_addr SHALL equal pc at all times.
REQ-017 In REQ, imem_req=1 when redirect_valid=0 and (if_valid=0 or if_ready=1); otherwise imem_req=0.
REQ-018 REQ and imem_req=1 and imem_gnt=1: next state WAIT; pc <= pc+4 (32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000); the granted address is latched as fetch_pc.
REQ-019 WAIT and imem_rvalid=1 and discard=0 and redirect_valid=0: if_valid <= 1, if_instr <= imem_rdata, if_pc <= fetch_pc; next state REQ.
REQ-020 WAIT and imem_rvalid=1 and discard=1: the response is dropped, discard <= 0, next state REQ, and the output buffer is unchanged by the response.
REQ-021 imem_req SHALL be 0 in WAIT.
REQ-022 Buffer drain: if_valid=1 and if_ready=1 with no load in the same cycle gives if_valid <= 0; a load and a drain in the same cycle leave if_valid=1 with the new data.
REQ-023 Redirect, any state: pc <= {redirect_target[31:2], 2'b00}; if_valid <= 0 (the buffered instruction is flushed even if if_ready=1 that cycle).
REQ-024 Redirect in WAIT with imem_rvalid=0: discard <= 1; the state remains WAIT.
REQ-025 Redirect in WAIT with imem_rvalid=1: the response is dropped, discard stays 0, next state REQ.
REQ-026 Redirect in REQ: no request is issued that cycle (REQ-017); the state remains REQ, and the fetch at the new pc starts the next cycle.
REQ-027 A redirect while discard=1 only updates pc; discard stays 1.
REQ-028 Output registers SHALL change only per REQ-019, REQ-022, REQ-023 and reset; if_instr and if_pc are stable while if_valid=1 and if_ready=0.
REQ-029 Steady-state throughput: one instruction per 2 cycles with single-cycle grant and response.

Reset
REQ-030 While rst_n=0 at a rising edge: pc <= RESET_PC, state <= REQ, discard <= 0, if_valid <= 0, if_instr <= 32'h0000_0013 (NOP), if_pc <= 32'h0.
REQ-031 imem_req SHALL be 0 in any cycle where rst_n=0.
REQ-032 Reset asserted during WAIT: any later imem_rvalid from the abandoned request is ignored until a new grant has occurred.
REQ-033 The first request is issued in the first cycle after rst_n goes high.

Verification
REQ-034 Reset release, gnt=1 every cycle, rvalid one cycle after each grant, if_ready=1: imem_addr 0,4,8; if_pc 0,4,8 each with if_valid=1; 2-cycle spacing.
REQ-035 if_ready=0 for 5 cycles with the buffer full: imem_req=0 and if_instr/if_pc held; if_ready=1 leads to a new request in the same cycle.
REQ-036 Redirect to 32'h0000_0103 while in WAIT and rvalid arrives 2 cycles later: the response is dropped; the next imem_addr=32'h0000_0100; the next if_pc=32'h0000_0100.
REQ-037 Redirect in the same cycle as rvalid: the response is dropped, if_valid=0 next cycle, and the next request goes to the target.
REQ-038 pc=32'hFFFF_FFFC granted: the next imem_addr=32'h0000_0000.
REQ-039 rst_n=0 mid-WAIT then released: imem_addr=RESET_PC, if_valid=0, and the stale rvalid produces no if_valid.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: redirect request, instruction-memory port and decode-side buffer.
// master = the fetch unit, slave = memory/decode environment.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    input  redirect_valid, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output redirect_valid, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry decode buffer, redirect flush.
// Response lands in the buffer the cycle after rvalid; no new request while the buffer is full and not draining.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic {ST_REQ, ST_WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_discard;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;

  logic        w_req;
  logic        w_grant;
  logic        w_load;

  // A request may only go out when the buffer will have room for its response.
  assign w_req   = rst_n && (r_state == ST_REQ) && !bus.redirect_valid &&
                   (!r_if_valid || bus.if_ready);
  assign w_grant = w_req && bus.imem_gnt;
  assign w_load  = (r_state == ST_WAIT) && bus.imem_rvalid && !r_discard &&
                   !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'h0000_0013;
      r_if_pc    <= 32'h0000_0000;
    end else begin
      if (bus.redirect_valid) begin
        r_pc <= {bus.redirect_target[31:2], 2'b00};
      end else if (w_grant) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_grant) begin
        r_fetch_pc <= r_pc;
      end

      // A redirect while waiting marks the in-flight response as stale.
      case (r_state)
        ST_REQ: begin
          if (w_grant) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            r_state   <= ST_REQ;
            r_discard <= 1'b0;
          end else if (bus.redirect_valid) begin
            r_discard <= 1'b1;
          end
        end
        default: r_state <= ST_REQ;
      endcase

      if (bus.redirect_valid) begin
        r_if_valid <= 1'b0;
      end else if (w_load) begin
        r_if_valid <= 1'b1;
        r_if_instr <= bus.imem_rdata;
        r_if_pc    <= r_fetch_pc;
      end else if (bus.if_ready) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_instr  = r_if_instr;
  assign bus.if_pc     = r_if_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic against a
// program-stream reference (expected pc sequence, epoch-tagged memory responses).
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory environment: a single pending response tagged with the epoch it was issued in.
  bit          pend_vld   = 1'b0;
  int          pend_cnt   = 0;
  logic [31:0] pend_addr  = '0;
  int          pend_epoch = 0;
  int          cur_epoch  = 0;

  // Reference: next fetch address, next expected instruction address, buffer occupancy.
  bit          m_known   = 1'b0;
  bit          m_wait    = 1'b0;
  bit          m_bv      = 1'b0;
  bit          held      = 1'b0;
  logic [31:0] m_pc      = '0;
  logic [31:0] stream_pc = '0;
  logic [31:0] h_pc      = '0;
  logic [31:0] h_instr   = '0;

  logic [31:0] last_req, last_addr, last_v, last_pc, last_instr;

  bit          r_rst, r_gnt, r_rdy, r_redir;
  logic [31:0] r_tgt;
  int          r_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_cycle(input bit rst, input bit gnt, input bit rdy, input bit redir,
                            input logic [31:0] tgt, input int lat);
    bit exp_req, rv, live_load, consumed, grant_env, grant_mdl;
    @(negedge clk);
    rst_n                = rst;
    rv                   = pend_vld && (pend_cnt == 0);
    bus.imem_rvalid      = rv;
    bus.imem_rdata       = rv ? mem_word(pend_addr) : $urandom;
    bus.imem_gnt         = gnt && !pend_vld;
    bus.redirect_valid   = redir;
    bus.redirect_target  = tgt;
    bus.if_ready         = rdy;
    #1;
    exp_req = rst && !m_wait && !redir && (!m_bv || rdy);
    chk_eq("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (m_known) begin
      chk_eq("imem_addr", bus.imem_addr, m_pc);
      chk_eq("if_valid", 32'(bus.if_valid), 32'(m_bv));
      if (m_bv) begin
        chk_eq("if_pc", bus.if_pc, stream_pc);
        chk_eq("if_instr", bus.if_instr, mem_word(stream_pc));
      end
      if (held) begin
        chk_eq("hold_pc", bus.if_pc, h_pc);
        chk_eq("hold_instr", bus.if_instr, h_instr);
      end
    end
    last_req   = 32'(bus.imem_req);
    last_addr  = bus.imem_addr;
    last_v     = 32'(bus.if_valid);
    last_pc    = bus.if_pc;
    last_instr = bus.if_instr;

    grant_env = bus.imem_req && bus.imem_gnt;
    grant_mdl = exp_req && bus.imem_gnt;
    live_load = rst && rv && (pend_epoch == cur_epoch) && !redir;
    consumed  = rst && m_bv && rdy && !redir;
    held      = rst && m_bv && !rdy && !redir;
    h_pc      = bus.if_pc;
    h_instr   = bus.if_instr;

    if (rv) pend_vld = 1'b0;
    else if (pend_vld) pend_cnt--;
    if (grant_env) begin
      pend_vld   = 1'b1;
      pend_cnt   = lat;
      pend_addr  = bus.imem_addr;
      pend_epoch = cur_epoch;
    end

    if (!rst) begin
      m_known   = 1'b1;
      m_pc      = RST_PC;
      stream_pc = RST_PC;
      m_wait    = 1'b0;
      m_bv      = 1'b0;
      cur_epoch++;
    end else begin
      if (rv) m_wait = 1'b0;
      if (grant_mdl) begin
        m_wait = 1'b1;
        m_pc   = m_pc + 32'd4;
      end
      if (consumed) stream_pc = stream_pc + 32'd4;
      if (redir) begin
        m_pc      = {tgt[31:2], 2'b00};
        stream_pc = m_pc;
        cur_epoch++;
      end
      if (redir) m_bv = 1'b0;
      else if (live_load) m_bv = 1'b1;
      else if (consumed) m_bv = 1'b0;
    end
  endtask

  initial begin
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.imem_gnt        = 1'b0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = '0;
    bus.if_ready        = 1'b0;

    for (int i = 0; i < 3; i++) step_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 0);

    // First cycle out of reset: request at RESET_PC, buffer empty with reset contents.
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("rst_req", last_req, 32'd1);
    chk_eq("rst_addr", last_addr, RST_PC);
    chk_eq("rst_valid", last_v, 32'd0);
    chk_eq("rst_instr", last_instr, 32'h0000_0013);
    chk_eq("rst_pc", last_pc, 32'h0);

    // Back-to-back fetches at 2-cycle spacing.
    for (int k = 0; k < 3; k++) begin
      step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
      chk_eq("seq_wait_req", last_req, 32'd0);
      step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
      chk_eq("seq_valid", last_v, 32'd1);
      chk_eq("seq_pc", last_pc, 32'(k * 4));
      chk_eq("seq_addr", last_addr, 32'((k + 1) * 4));
    end

    // Decode stall with a full buffer.
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 0);
    for (int k = 0; k < 5; k++) begin
      step_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 0);
      chk_eq("stall_req", last_req, 32'd0);
      chk_eq("stall_pc", last_pc, 32'd12);
      chk_eq("stall_valid", last_v, 32'd1);
    end
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 2);
    chk_eq("unstall_req", last_req, 32'd1);
    chk_eq("unstall_addr", last_addr, 32'd16);

    // Redirect while waiting; response arrives two cycles later and is dropped.
    step_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 0);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("disc_wait_req", last_req, 32'd0);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("disc_rsp_req", last_req, 32'd0);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("disc_valid", last_v, 32'd0);
    chk_eq("disc_req", last_req, 32'd1);
    chk_eq("disc_addr", last_addr, 32'h0000_0100);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("disc_if_valid", last_v, 32'd1);
    chk_eq("disc_if_pc", last_pc, 32'h0000_0100);

    // Redirect in the same cycle as rvalid.
    step_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 0);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("same_valid", last_v, 32'd0);
    chk_eq("same_req", last_req, 32'd1);
    chk_eq("same_addr", last_addr, 32'h0000_0200);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);

    // Redirect in REQ to an unaligned top-of-memory target, then wrap.
    step_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 0);
    chk_eq("rdreq_req", last_req, 32'd0);
    chk_eq("rdreq_pc", last_pc, 32'h0000_0200);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("top_addr", last_addr, 32'hFFFF_FFFC);
    chk_eq("top_req", last_req, 32'd1);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("wrap_addr", last_addr, 32'h0000_0000);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 2);
    chk_eq("wrap_if_pc", last_pc, 32'hFFFF_FFFC);
    chk_eq("wrap_req", last_req, 32'd1);

    // Reset mid-WAIT; the stale response lands after release.
    step_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 0);
    step_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 0);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("mrst_addr", last_addr, RST_PC);
    chk_eq("mrst_valid", last_v, 32'd0);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    chk_eq("stale_valid", last_v, 32'd0);
    chk_eq("stale_req", last_req, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r_rst   = ($urandom_range(0, 299) != 0);
      r_gnt   = ($urandom_range(0, 9) < 7);
      r_rdy   = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 19) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
      r_lat   = $urandom_range(0, 2);
      step_cycle(r_rst, r_gnt, r_rdy, r_redir, r_tgt, r_lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
